// File: rtl/ifu_if.sv
// ifu_if: bundles every non-clock/reset signal of the instruction fetch unit.
//   AXI4-Lite-style read channel : araddr, arvalid, arready, rdata, rresp, rvalid, rready
//   Decode handshake             : instruction, pc, ifu_send_valid, ifu_receive_ready
//   PC commit from decode        : pc_next, pc_write_enable
//   Status                       : fault, fault_cause, fetch_count
// Modport master is the IFU side; modport slave is the memory/decode side.
interface ifu_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        ifu_send_valid;
    logic        ifu_receive_ready;
    logic [31:0] pc_next;
    logic        pc_write_enable;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fetch_count;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid,
        output instruction, pc, ifu_send_valid,
        input  ifu_receive_ready, pc_next, pc_write_enable,
        output fault, fault_cause, fetch_count
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid,
        input  instruction, pc, ifu_send_valid,
        output ifu_receive_ready, pc_next, pc_write_enable,
        input  fault, fault_cause, fetch_count
    );
endinterface

// File: rtl/ifu.sv
// ifu: non-speculative instruction fetch unit for the multi-cycle NPC core.
// Holds the PC, issues one read per instruction, offers {instruction, pc} to decode and
// waits for decode to commit the next PC before fetching again.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - ifu_if.master: read channel, decode handshake, PC commit and status outputs
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input logic   clk,
    input logic   rst,
    ifu_if.master bus
);

    typedef enum logic [2:0] {
        StAddr,
        StData,
        StSend,
        StWait,
        StHalt
    } state_t;

    localparam logic [1:0] CauseNone  = 2'b00;
    localparam logic [1:0] CauseBus   = 2'b01;
    localparam logic [1:0] CauseAlign = 2'b10;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_instruction;
    logic [31:0] w_instruction_next;
    logic [31:0] r_fetch_count;
    logic [31:0] w_fetch_count_next;
    logic [1:0]  r_fault_cause;
    logic [1:0]  w_fault_cause_next;
    logic        w_commit_aligned;

    assign w_commit_aligned = (bus.pc_next[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StAddr;
            r_pc          <= RESET_PC;
            r_instruction <= 32'h0;
            r_fetch_count <= 32'h0;
            r_fault_cause <= CauseNone;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_instruction <= w_instruction_next;
            r_fetch_count <= w_fetch_count_next;
            r_fault_cause <= w_fault_cause_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_instruction_next = r_instruction;
        w_fetch_count_next = r_fetch_count;
        w_fault_cause_next = r_fault_cause;

        unique case (r_state)
            StAddr: begin
                if (bus.arready) begin
                    w_state_next = StData;
                end
            end
            StData: begin
                if (bus.rvalid) begin
                    // Captured even on an error response so the faulting word is visible.
                    w_instruction_next = bus.rdata;
                    if (bus.rresp == 2'b00) begin
                        w_state_next = StSend;
                    end else begin
                        w_state_next       = StHalt;
                        w_fault_cause_next = CauseBus;
                    end
                end
            end
            StSend: begin
                if (bus.ifu_receive_ready) begin
                    w_fetch_count_next = r_fetch_count + 32'd1;
                    w_state_next       = StWait;
                    // Same-cycle commit collapses the WAIT state.
                    if (bus.pc_write_enable) begin
                        if (w_commit_aligned) begin
                            w_pc_next    = bus.pc_next;
                            w_state_next = StAddr;
                        end else begin
                            w_state_next       = StHalt;
                            w_fault_cause_next = CauseAlign;
                        end
                    end
                end
            end
            StWait: begin
                if (bus.pc_write_enable) begin
                    if (w_commit_aligned) begin
                        w_pc_next    = bus.pc_next;
                        w_state_next = StAddr;
                    end else begin
                        w_state_next       = StHalt;
                        w_fault_cause_next = CauseAlign;
                    end
                end
            end
            StHalt: begin
                w_state_next = StHalt;
            end
            default: begin
                w_state_next = StHalt;
            end
        endcase
    end

    assign bus.araddr         = r_pc;
    assign bus.arvalid        = (r_state == StAddr);
    assign bus.rready         = (r_state == StData);
    assign bus.ifu_send_valid = (r_state == StSend);
    assign bus.instruction    = r_instruction;
    assign bus.pc             = r_pc;
    assign bus.fault          = (r_state == StHalt);
    assign bus.fault_cause    = r_fault_cause;
    assign bus.fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: self-checking bench for ifu. A transaction-level model of the fetch loop is
// updated from the inputs applied each cycle; every cycle all DUT outputs are compared
// against it. Directed sequences add literal expectations, then a randomized run follows.
module tb_ifu;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifu_if bus ();

    ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [31:0] ResetPc = 32'h8000_0000;

    // Model phases of one instruction's life.
    localparam int PhFetch  = 0;
    localparam int PhRead   = 1;
    localparam int PhOffer  = 2;
    localparam int PhCommit = 3;
    localparam int PhHalted = 4;

    int          errors = 0;
    int          checks = 0;
    int          m_ph;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_count;
    logic [1:0]  m_cause;
    logic        mem_pending;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("arvalid", {31'b0, bus.arvalid}, {31'b0, m_ph == PhFetch});
        if (m_ph == PhFetch) chk("araddr", bus.araddr, m_pc);
        chk("rready", {31'b0, bus.rready}, {31'b0, m_ph == PhRead});
        chk("send_valid", {31'b0, bus.ifu_send_valid}, {31'b0, m_ph == PhOffer});
        chk("instruction", bus.instruction, m_instr);
        chk("pc", bus.pc, m_pc);
        chk("fault", {31'b0, bus.fault}, {31'b0, m_ph == PhHalted});
        chk("fault_cause", {30'b0, bus.fault_cause}, {30'b0, m_cause});
        chk("fetch_count", bus.fetch_count, m_count);
    endtask

    task automatic model_commit();
        if (bus.pc_write_enable) begin
            if (bus.pc_next % 4 == 0) begin
                m_pc = bus.pc_next;
                m_ph = PhFetch;
            end else begin
                m_ph    = PhHalted;
                m_cause = 2'b10;
            end
        end
    endtask

    // Applies the inputs currently driven to the model, as the DUT will on the next edge.
    task automatic model_update();
        if (rst) begin
            m_ph    = PhFetch;
            m_pc    = ResetPc;
            m_instr = 32'h0;
            m_count = 32'h0;
            m_cause = 2'b00;
        end else begin
            case (m_ph)
                PhFetch: if (bus.arready) m_ph = PhRead;
                PhRead: begin
                    if (bus.rvalid) begin
                        m_instr = bus.rdata;
                        if (bus.rresp == 2'b00) begin
                            m_ph = PhOffer;
                        end else begin
                            m_ph    = PhHalted;
                            m_cause = 2'b01;
                        end
                    end
                end
                PhOffer: begin
                    if (bus.ifu_receive_ready) begin
                        m_count = m_count + 1;
                        m_ph    = PhCommit;
                        model_commit();
                    end
                end
                PhCommit: model_commit();
                default: ;
            endcase
        end
        if (rst) mem_pending = 1'b0;
        else if (bus.arvalid && bus.arready) mem_pending = 1'b1;
        else if (bus.rvalid && bus.rready) mem_pending = 1'b0;
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        bus.arready           = 1'b0;
        bus.rvalid            = 1'b0;
        bus.rdata             = 32'h0;
        bus.rresp             = 2'b00;
        bus.ifu_receive_ready = 1'b0;
        bus.pc_write_enable   = 1'b0;
        bus.pc_next           = 32'h0;
    endtask

    // One zero-wait fetch ending with an aligned same-cycle commit.
    task automatic quick_fetch(input logic [31:0] word, input logic [31:0] next);
        bus.arready = 1'b1;
        advance();
        bus.arready = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rdata   = word;
        bus.rresp   = 2'b00;
        advance();
        bus.rvalid            = 1'b0;
        bus.ifu_receive_ready = 1'b1;
        bus.pc_write_enable   = 1'b1;
        bus.pc_next           = next;
        advance();
        idle_inputs();
    endtask

    initial begin
        logic [31:0] rnd;
        int          halt_cycles;

        m_ph        = PhFetch;
        m_pc        = ResetPc;
        m_instr     = 32'h0;
        m_count     = 32'h0;
        m_cause     = 2'b00;
        mem_pending = 1'b0;
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        advance();
        advance();

        // Basic fetch: cycle 1 is the first cycle after reset.
        rst         = 1'b0;
        chk("c1_arvalid", {31'b0, bus.arvalid}, 32'd1);
        chk("c1_araddr", bus.araddr, 32'h8000_0000);
        chk("c1_rready", {31'b0, bus.rready}, 32'd0);
        bus.arready = 1'b1;
        advance();
        bus.arready = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'h0000_0413;
        advance();
        chk("c3_send_valid", {31'b0, bus.ifu_send_valid}, 32'd1);
        chk("c3_instruction", bus.instruction, 32'h0000_0413);
        chk("c3_pc", bus.pc, 32'h8000_0000);
        bus.rvalid            = 1'b0;
        bus.rdata             = 32'hFFFF_FFFF;
        bus.ifu_receive_ready = 1'b1;
        bus.pc_write_enable   = 1'b1;
        bus.pc_next           = 32'h8000_0004;
        advance();
        chk("c4_araddr", bus.araddr, 32'h8000_0004);
        chk("c4_count", bus.fetch_count, 32'd1);
        idle_inputs();

        // Backpressure on every handshake.
        repeat (3) begin
            advance();
            chk("bp_araddr", bus.araddr, 32'h8000_0004);
        end
        bus.arready = 1'b1;
        advance();
        bus.arready = 1'b0;
        repeat (4) begin
            bus.rdata = 32'hA5A5_0000 ^ $urandom;
            advance();
            chk("bp_instr_hold", bus.instruction, 32'h0000_0413);
        end
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h0010_0093;
        advance();
        bus.rvalid = 1'b0;
        repeat (2) begin
            advance();
            chk("bp_send_hold", {31'b0, bus.ifu_send_valid}, 32'd1);
            chk("bp_pc_hold", bus.pc, 32'h8000_0004);
            chk("bp_instr", bus.instruction, 32'h0010_0093);
        end
        bus.ifu_receive_ready = 1'b1;
        advance();
        chk("bp_count", bus.fetch_count, 32'd2);

        // Separate commit: five cycles waiting for decode.
        bus.ifu_receive_ready = 1'b0;
        repeat (4) begin
            advance();
            chk("wait_arvalid", {31'b0, bus.arvalid}, 32'd0);
        end
        bus.pc_write_enable = 1'b1;
        bus.pc_next         = 32'h8000_0100;
        advance();
        chk("commit_araddr", bus.araddr, 32'h8000_0100);
        idle_inputs();

        // Bus error response.
        bus.arready = 1'b1;
        advance();
        bus.arready = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rresp   = 2'b10;
        bus.rdata   = 32'hDEAD_BEEF;
        advance();
        chk("berr_fault", {31'b0, bus.fault}, 32'd1);
        chk("berr_cause", {30'b0, bus.fault_cause}, 32'd1);
        idle_inputs();
        bus.arready           = 1'b1;
        bus.ifu_receive_ready = 1'b1;
        bus.pc_write_enable   = 1'b1;
        repeat (3) begin
            advance();
            chk("halt_no_send", {31'b0, bus.ifu_send_valid}, 32'd0);
        end

        // Reset out of HALT.
        rst = 1'b1;
        advance();
        chk("rst_halt_arvalid", {31'b0, bus.arvalid}, 32'd1);
        chk("rst_halt_araddr", bus.araddr, 32'h8000_0000);
        chk("rst_halt_fault", {31'b0, bus.fault}, 32'd0);
        chk("rst_halt_count", bus.fetch_count, 32'd0);
        rst = 1'b0;
        idle_inputs();

        // Misaligned commit.
        bus.arready = 1'b1;
        advance();
        bus.arready = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'h0000_0013;
        advance();
        bus.rvalid            = 1'b0;
        bus.ifu_receive_ready = 1'b1;
        bus.pc_write_enable   = 1'b1;
        bus.pc_next           = 32'h8000_0002;
        advance();
        chk("mis_cause", {30'b0, bus.fault_cause}, 32'd2);
        chk("mis_pc", bus.pc, 32'h8000_0000);
        idle_inputs();
        rst = 1'b1;
        advance();
        rst = 1'b0;

        // Reset while waiting for read data.
        bus.arready = 1'b1;
        advance();
        bus.arready = 1'b0;
        chk("data_rready", {31'b0, bus.rready}, 32'd1);
        rst = 1'b1;
        advance();
        chk("rst_data_arvalid", {31'b0, bus.arvalid}, 32'd1);
        chk("rst_data_araddr", bus.araddr, 32'h8000_0000);
        chk("rst_data_count", bus.fetch_count, 32'd0);
        rst = 1'b0;

        // Counter wrap.
        force dut.r_fetch_count = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        advance();
        release dut.r_fetch_count;
        quick_fetch(32'h0000_0517, 32'h8000_0008);
        chk("wrap_count", bus.fetch_count, 32'd0);
        chk("wrap_araddr", bus.araddr, 32'h8000_0008);

        // Randomized traffic.
        halt_cycles = 0;
        for (int i = 0; i < 4000; i++) begin
            halt_cycles = bus.fault ? halt_cycles + 1 : 0;
            rst = ($urandom_range(0, 299) == 0) || (halt_cycles > 3);
            bus.arready = ($urandom_range(0, 2) != 0);
            bus.rvalid  = mem_pending && ($urandom_range(0, 2) != 0);
            bus.rdata   = $urandom;
            if (bus.rvalid) bus.rresp = ($urandom_range(0, 39) == 0) ? 2'(
                $urandom_range(1, 3)) : 2'b00;
            else bus.rresp = 2'($urandom_range(0, 3));
            bus.ifu_receive_ready = ($urandom_range(0, 1) != 0);
            bus.pc_write_enable   = ($urandom_range(0, 2) == 0);
            rnd = $urandom;
            if ($urandom_range(0, 29) != 0) rnd[1:0] = 2'b00;
            bus.pc_next = rnd;
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
